axis_dma_packetizer: RTL and testbench

- Sits directly downstream of the receive chain's DMA readout stream (sparse sample buffer output) and upstream of the AXI DMA S2MM slave.
- Registers the stream and inserts `last` every `packet_beats` beats, so each DMA transfer has a bounded, software-chosen length.
- Ends a packet early when the upstream stream asserts `last` (end of buffer readout).
- Reports the number of packets emitted.

---
 rtl/axis_dma_packetizer.sv | 121 ++++++++++++
 tb/tb_axis_dma_packetizer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dma_packetizer.sv
// AXI-stream packetizer between the sample-buffer readout and the DMA S2MM slave.
// It registers the stream and forces `last` every packet_beats beats, or earlier when the upstream stream ends.
module axis_dma_packetizer #(
    parameter int DWIDTH               = 128,
    parameter int MAX_PACKET_BEATS     = 4096,
    parameter int DEFAULT_PACKET_BEATS = 256,
    parameter int LEN_WIDTH            = $clog2(MAX_PACKET_BEATS) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DWIDTH-1:0]    data_in_data,
    input  logic                 data_in_valid,
    input  logic                 data_in_last,
    output logic                 data_in_ready,
    output logic [DWIDTH-1:0]    data_out_data,
    output logic                 data_out_valid,
    output logic                 data_out_last,
    input  logic                 data_out_ready,
    input  logic [LEN_WIDTH-1:0] config_data,
    input  logic                 config_valid,
    output logic [31:0]          packet_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PACKET_BEATS);
    localparam logic [LEN_WIDTH-1:0] DEF_LEN = LEN_WIDTH'(DEFAULT_PACKET_BEATS);

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] v);
        return (v > MAX_LEN) ? MAX_LEN : v;
    endfunction

    logic [0:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] active_len_q, active_len_d;
    logic [LEN_WIDTH-1:0] pending_len_q, pending_len_d;
    logic [LEN_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [DWIDTH-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [31:0]          packet_count_q, packet_count_d;

    logic                 in_accept;
    logic                 out_fire;
    logic [LEN_WIDTH-1:0] len_sel;
    logic [LEN_WIDTH-1:0] beat_next;
    logic                 last_next;

    assign data_in_ready  = reset && (!out_valid_q || data_out_ready);
    assign in_accept      = data_in_valid && data_in_ready;
    assign out_fire       = out_valid_q && data_out_ready;

    assign data_out_data  = out_data_q;
    assign data_out_valid = out_valid_q;
    assign data_out_last  = out_last_q;
    assign packet_count   = packet_count_q;

    always_comb begin
        // The first beat of a packet decides with the freshly adopted pending length.
        len_sel        = (state_q == ST_IDLE) ? pending_len_q : active_len_q;
        beat_next      = (state_q == ST_IDLE) ? LEN_WIDTH'(1) : beat_count_q + LEN_WIDTH'(1);
        last_next      = (beat_next == len_sel) || data_in_last;

        state_d        = state_q;
        active_len_d   = active_len_q;
        pending_len_d  = pending_len_q;
        beat_count_d   = beat_count_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;

        if (in_accept) begin
            out_data_d  = data_in_data;
            out_valid_d = 1'b1;
            out_last_d  = last_next;
            if (state_q == ST_IDLE) begin
                active_len_d = pending_len_q;
            end
            if (last_next) begin
                state_d      = ST_IDLE;
                beat_count_d = '0;
            end else begin
                state_d      = ST_BODY;
                beat_count_d = beat_next;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // A zero length would never terminate a packet, so it is ignored.
        if (config_valid && (config_data != '0)) begin
            pending_len_d = clamp_len(config_data);
        end

        packet_count_d = packet_count_q + ((out_fire && out_last_q) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            active_len_q   <= DEF_LEN;
            pending_len_q  <= DEF_LEN;
            beat_count_q   <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            packet_count_q <= '0;
        end else begin
            state_q        <= state_d;
            active_len_q   <= active_len_d;
            pending_len_q  <= pending_len_d;
            beat_count_q   <= beat_count_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            packet_count_q <= packet_count_d;
        end
    end

endmodule

// File: tb/tb_axis_dma_packetizer.sv
// Scoreboard bench for axis_dma_packetizer: directed beats push expected data/last,
// and an independent monitor pops and compares on every output transfer.
module tb_axis_dma_packetizer;

    localparam int DW = 128;
    localparam int LW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in_data;
    logic          data_in_valid;
    logic          data_in_last;
    logic          data_in_ready;
    logic [DW-1:0] data_out_data;
    logic          data_out_valid;
    logic          data_out_last;
    logic          data_out_ready;
    logic [LW-1:0] config_data;
    logic          config_valid;
    logic [31:0]   packet_count;

    axis_dma_packetizer dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_data   (data_in_data),
        .data_in_valid  (data_in_valid),
        .data_in_last   (data_in_last),
        .data_in_ready  (data_in_ready),
        .data_out_data  (data_out_data),
        .data_out_valid (data_out_valid),
        .data_out_last  (data_out_last),
        .data_out_ready (data_out_ready),
        .config_data    (config_data),
        .config_valid   (config_valid),
        .packet_count   (packet_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rnd_rdy = 1'b0;
    logic rdy_fix = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            data_out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_fix;
        end
    end

    // Monitor: checks order, last flag, one-cycle latency and stall stability.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        int            start_cyc;
        exp_t          e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        start_cyc  = 0;
        forever begin
            @(negedge clk);
            if (data_out_valid === 1'b1) begin
                if (prev_stall) begin
                    total++;
                    if (data_out_data !== prev_data || data_out_last !== prev_last) begin
                        bad++;
                        $display("FAIL stall_hold: data=%0h last=%b, held data=%0h last=%b",
                                 data_out_data, data_out_last, prev_data, prev_last);
                    end
                end else begin
                    start_cyc = cyc;
                end
                if (data_out_ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: data=%0h last=%b, no beat expected",
                                 data_out_data, data_out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_out_data !== e.d || data_out_last !== e.l) begin
                            bad++;
                            $display("FAIL beat: data=%0h last=%b, expected data=%0h last=%b",
                                     data_out_data, data_out_last, e.d, e.l);
                        end
                        total++;
                        if (start_cyc != e.acc + 1) begin
                            bad++;
                            $display("FAIL latency: presented cycle %0d, expected %0d",
                                     start_cyc, e.acc + 1);
                        end
                    end
                end
            end
            prev_stall = (data_out_valid === 1'b1) && (data_out_ready !== 1'b1);
            prev_data  = data_out_data;
            prev_last  = data_out_last;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic send_beat(input int d, input logic il, input logic el);
        exp_t e;
        int   g;
        g = 0;
        data_in_data  = DW'(d);
        data_in_valid = 1'b1;
        data_in_last  = il;
        @(negedge clk);
        while (data_in_ready !== 1'b1 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (data_in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: beat %0d never accepted", d);
        end else begin
            e.d   = DW'(d);
            e.l   = el;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
    endtask

    task automatic cfg(input int v);
        config_data  = LW'(v);
        config_valid = 1'b1;
        @(posedge clk);
        #1;
        config_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        config_valid  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain_check(input string name, input int exp_cnt);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_count"}, 64'(packet_count), 64'(exp_cnt));
        chk({name, "_idle"}, 64'(data_out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        data_in_data  = '0;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        config_data   = '0;
        config_valid  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(data_out_valid), 64'd0);
        chk("rst_last", 64'(data_out_last), 64'd0);
        chk("rst_data", 64'(data_out_data), 64'd0);
        chk("rst_count", 64'(packet_count), 64'd0);
        chk("rst_in_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Length 4, twelve beats
        cfg(4);
        for (int i = 0; i < 12; i++) send_beat(i, 1'b0, (i % 4) == 3);
        drain_check("len4", 3);

        // Early termination by upstream last, then a full 8-beat packet
        do_reset();
        cfg(8);
        for (int i = 0; i < 5; i++) send_beat(i, i == 4, i == 4);
        for (int i = 5; i < 13; i++) send_beat(i, 1'b0, i == 12);
        drain_check("early", 2);

        // Mid-packet config change applies to the next packet only
        do_reset();
        cfg(4);
        send_beat(0, 1'b0, 1'b0);
        send_beat(1, 1'b0, 1'b0);
        cfg(2);
        for (int i = 2; i < 12; i++) send_beat(i, 1'b0, (i == 3) || (i >= 4 && (i % 2) == 1));
        drain_check("midcfg", 5);
        cfg(0);
        send_beat(12, 1'b0, 1'b0);
        send_beat(13, 1'b0, 1'b1);
        drain_check("cfg0", 6);
        cfg(5000);
        for (int k = 0; k < 4096; k++) send_beat(100 + k, 1'b0, k == 4095);
        drain_check("clamp", 7);

        // Random backpressure, length 16
        do_reset();
        rnd_rdy = 1'b1;
        cfg(16);
        for (int i = 0; i < 1000; i++) send_beat(i, 1'b0, (i % 16) == 15);
        drain_check("bp", 62);
        rnd_rdy = 1'b0;

        // Coinciding lasts, length 1, and config written with the first beat
        do_reset();
        cfg(4);
        for (int i = 0; i < 4; i++) send_beat(i, i == 3, i == 3);
        for (int i = 4; i < 8; i++) send_beat(i, 1'b0, i == 7);
        drain_check("coincide", 2);
        cfg(1);
        send_beat(8, 1'b0, 1'b1);
        send_beat(9, 1'b0, 1'b1);
        drain_check("len1", 4);
        cfg(4);
        config_data  = LW'(2);
        config_valid = 1'b1;
        send_beat(10, 1'b0, 1'b0);
        config_valid = 1'b0;
        for (int i = 11; i < 16; i++) send_beat(i, 1'b0, (i == 13) || (i == 15));
        drain_check("samecfg", 6);

        // Reset in the middle of a packet
        do_reset();
        cfg(8);
        for (int i = 0; i < 8; i++) send_beat(i, 1'b0, i == 7);
        drain_check("prerst", 1);
        for (int i = 8; i < 11; i++) send_beat(i, 1'b0, 1'b0);
        rdy_fix = 1'b0;
        reset   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 64'(data_out_valid), 64'd0);
        chk("midrst_count", 64'(packet_count), 64'd0);
        chk("midrst_in_ready", 64'(data_in_ready), 64'd0);
        chk("midrst_inflight", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        rdy_fix = 1'b1;
        for (int i = 0; i < 256; i++) send_beat(1000 + i, 1'b0, i == 255);
        drain_check("default", 1);

        // Packet counter wrap
        force dut.packet_count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.packet_count_q;
        chk("wrap_preset", 64'(packet_count), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        cfg(1);
        send_beat(7, 1'b0, 1'b1);
        drain_check("wrap", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
